// File: rtl/mbr_store_rmw_pkg.sv
// rtl/mbr_store_rmw_pkg.sv - size codes, state encoding and access checks shared with the load path
package mbr_store_rmw_pkg;

    typedef enum logic [2:0] {
        BIT8    = 3'b000,
        BIT_U8  = 3'b001,
        BIT16   = 3'b010,
        BIT_U16 = 3'b011,
        BIT32   = 3'b100
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Unsupported codes and misaligned halves/words are rejected before any bus traffic.
    function automatic logic access_err(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            BIT8, BIT_U8:   return 1'b0;
            BIT16, BIT_U16: return addr_lo[0];
            BIT32:          return addr_lo != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mbr_store_rmw_if.sv
// rtl/mbr_store_rmw_if.sv - word-wide memory bus between the store unit and memory
interface mbr_store_rmw_if;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mbr_store_rmw_store_merge.sv
// rtl/mbr_store_rmw_store_merge.sv - combinational lane merge of store data into an existing word
module store_merge
    import mbr_store_rmw_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            BIT8, BIT_U8:   merged[{addr_lo, 3'b000} +: 8] = data[7:0];
            BIT16, BIT_U16: begin
                if (addr_lo[1]) merged[31:16] = data[15:0];
                else            merged[15:0]  = data[15:0];
            end
            BIT32:          merged = data;
            default:        merged = old_word;
        endcase
    end

endmodule

// File: rtl/mbr_store_rmw.sv
// rtl/mbr_store_rmw.sv - store unit: byte/half stores by read-modify-write, words written directly
module mbr_store_rmw
    import mbr_store_rmw_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         st_req,
    input  logic [31:0]  st_addr,
    input  logic [31:0]  st_data,
    input  logic [2:0]   size,
    output logic         st_busy,
    output logic         st_done,
    output logic         st_err,
    mbr_store_rmw_if.master mem
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e      state, state_n;
    logic [31:0] addr_q, wdata_q, data_q, merged;
    logic [2:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic        err_q;
    logic [CW-1:0] wait_cnt;
    logic        timed_out;
    logic        cap_err;

    assign cap_err   = access_err(size, st_addr[1:0]);
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));

    store_merge u_merge (
        .old_word (mem.mem_rdata),
        .data     (data_q),
        .size     (size_q),
        .addr_lo  (addr_lo_q),
        .merged   (merged)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (st_req) begin
                    if (cap_err)              state_n = ST_DONE;
                    else if (size == BIT32)   state_n = ST_WRITE;
                    else                      state_n = ST_READ;
                end
            end
            ST_READ: begin
                if (mem.mem_ack)    state_n = ST_WRITE;
                else if (timed_out) state_n = ST_DONE;
            end
            ST_WRITE: begin
                if (mem.mem_ack || timed_out) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
            size_q    <= '0;
            addr_lo_q <= '0;
            err_q     <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (st_req) begin
                        addr_q    <= {st_addr[31:2], 2'b00};
                        addr_lo_q <= st_addr[1:0];
                        data_q    <= st_data;
                        size_q    <= size;
                        err_q     <= cap_err;
                        wait_cnt  <= '0;
                        if (!cap_err && size == BIT32) wdata_q <= st_data;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (mem.mem_ack) begin
                        wait_cnt <= '0;
                        if (state == ST_READ) wdata_q <= merged;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign st_busy       = state != ST_IDLE;
    assign st_done       = state == ST_DONE;
    assign st_err        = err_q && (state == ST_DONE);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_rd    = state == ST_READ;
    assign mem.mem_wr    = state == ST_WRITE;

endmodule

// File: tb/tb_mbr_store_rmw.sv
// tb/tb_mbr_store_rmw.sv - directed and randomized store checks against a byte-lane reference model
module tb_mbr_store_rmw;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_req;
    logic [31:0] st_addr, st_data;
    logic [2:0]  size;
    logic        st_busy, st_done, st_err;

    int passed = 0;
    int total  = 0;

    mbr_store_rmw_if mem_bus ();

    mbr_store_rmw #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .st_req  (st_req),
        .st_addr (st_addr),
        .st_data (st_data),
        .size    (size),
        .st_busy (st_busy),
        .st_done (st_done),
        .st_err  (st_err),
        .mem     (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Runs one store from an idle negedge acting as the memory; returns what the bus showed.
    task automatic do_store(
        input  logic [31:0] a, d, input logic [2:0] sz, input logic [31:0] rdata,
        input  int rw, ww, input bit no_ack,
        output int lat, output bit err, output logic [31:0] wword, output logic [31:0] baddr,
        output bit saw_rd, saw_wr, output int done_cnt, rd_cycles, output bit bad_flags
    );
        int rcnt = 0, wcnt = 0, cyc = 0;
        bit seen_done = 0;
        lat = 0; err = 0; wword = 'x; baddr = 'x; saw_rd = 0; saw_wr = 0;
        done_cnt = 0; rd_cycles = 0; bad_flags = 0;
        st_req = 1'b1; st_addr = a; st_data = d; size = sz;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            st_req = 1'b0;
            mem_bus.mem_ack = 1'b0;
            mem_bus.mem_rdata = $urandom;
            if (mem_bus.mem_rd && mem_bus.mem_wr) bad_flags = 1;
            if (st_err && !st_done) bad_flags = 1;
            if (st_done) begin
                done_cnt++;
                if (!seen_done) begin lat = cyc + 1; err = st_err; end
                seen_done = 1;
            end
            if (mem_bus.mem_rd) begin
                if (!saw_rd) baddr = mem_bus.mem_addr;
                saw_rd = 1; rd_cycles++;
                if (!no_ack && rcnt == rw) begin
                    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = rdata;
                end else rcnt++;
            end
            if (mem_bus.mem_wr) begin
                if (!saw_wr && !saw_rd) baddr = mem_bus.mem_addr;
                saw_wr = 1;
                if (!no_ack && wcnt == ww) begin
                    mem_bus.mem_ack = 1'b1; wword = mem_bus.mem_wdata;
                end else wcnt++;
            end
            if (seen_done && !st_busy) break;
        end
        mem_bus.mem_ack = 1'b0;
    endtask

    initial begin
        int lat, done_cnt, rd_cycles;
        bit err, saw_rd, saw_wr, bad;
        logic [31:0] wword, baddr;

        reset = 1'b1; st_req = 1'b0; st_addr = '0; st_data = '0; size = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", st_busy, 0);
        check("rst_done", st_done, 0);
        check("rst_err", st_err, 0);
        check("rst_rd_wr", {mem_bus.mem_rd, mem_bus.mem_wr}, 0);
        check("rst_addr", mem_bus.mem_addr, 0);
        check("rst_wdata", mem_bus.mem_wdata, 0);
        reset = 1'b0;

        // Acks while idle must not start anything.
        mem_bus.mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ack_busy", {st_busy, st_done}, 0);
        mem_bus.mem_ack = 1'b0;

        do_store(32'h1002, 32'hAB, 3'b000, 32'h11223344, 1, 1, 0,
                 lat, err, wword, baddr, saw_rd, saw_wr, done_cnt, rd_cycles, bad);
        check("byte_addr", baddr, 32'h1000);
        check("byte_wdata", wword, 32'h11AB3344);
        check("byte_done_cnt", done_cnt, 1);
        check("byte_err", err, 0);
        check("byte_lat", lat, 6);

        do_store(32'h2002, 32'hBEEF, 3'b010, 32'h11223344, 0, 0, 0,
                 lat, err, wword, baddr, saw_rd, saw_wr, done_cnt, rd_cycles, bad);
        check("half_wdata", wword, 32'hBEEF3344);
        check("half_lat", lat, 4);

        do_store(32'h3000, 32'hDEADBEEF, 3'b100, 32'h0, 0, 0, 0,
                 lat, err, wword, baddr, saw_rd, saw_wr, done_cnt, rd_cycles, bad);
        check("word_no_rd", saw_rd, 0);
        check("word_wdata", wword, 32'hDEADBEEF);
        check("word_lat", lat, 3);

        do_store(32'h3001, 32'h1234, 3'b010, 32'h0, 0, 0, 0,
                 lat, err, wword, baddr, saw_rd, saw_wr, done_cnt, rd_cycles, bad);
        check("mis_half_err_lat", {err, 8'(lat)}, {1'b1, 8'd2});
        check("mis_half_no_bus", {saw_rd, saw_wr}, 0);

        do_store(32'h4000, 32'h1234, 3'b111, 32'h0, 0, 0, 0,
                 lat, err, wword, baddr, saw_rd, saw_wr, done_cnt, rd_cycles, bad);
        check("size7_err_lat", {err, 8'(lat)}, {1'b1, 8'd2});
        check("size7_no_bus", {saw_rd, saw_wr}, 0);

        do_store(32'h5001, 32'h55, 3'b001, 32'h0, 0, 0, 1,
                 lat, err, wword, baddr, saw_rd, saw_wr, done_cnt, rd_cycles, bad);
        check("tmo_rd_cycles", rd_cycles, 4);
        check("tmo_err", err, 1);
        check("tmo_no_wr", saw_wr, 0);
        check("tmo_done_cnt", done_cnt, 1);

        // Reset while in WRITE, colliding with st_req and mem_ack.
        st_req = 1'b1; st_addr = 32'h6000; st_data = 32'hCAFEF00D; size = 3'b100;
        @(negedge clk);
        st_req = 1'b0;
        check("rst_mid_in_write", mem_bus.mem_wr, 1);
        reset = 1'b1; st_req = 1'b1; mem_bus.mem_ack = 1'b1;
        @(negedge clk);
        check("rst_mid_idle", {st_busy, st_done, mem_bus.mem_wr}, 0);
        reset = 1'b0; st_req = 1'b0; mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        check("rst_mid_no_done", {st_busy, st_done}, 0);
        do_store(32'h6004, 32'h0BADCAFE, 3'b100, 32'h0, 1, 0, 0,
                 lat, err, wword, baddr, saw_rd, saw_wr, done_cnt, rd_cycles, bad);
        check("post_rst_wdata", wword, 32'h0BADCAFE);
        check("post_rst_ok", {err, 8'(done_cnt)}, {1'b0, 8'd1});

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, d, rd, mask, exp_w;
            logic [2:0]  sz;
            int rw, ww, exp_lat, sh;
            bit na, bad_acc, is_word;
            a = $urandom; d = $urandom; rd = $urandom;
            sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            rw = $urandom_range(0, 3); ww = $urandom_range(0, 3);
            na = ($urandom_range(0, 7) == 0);
            do_store(a, d, sz, rd, rw, ww, na,
                     lat, err, wword, baddr, saw_rd, saw_wr, done_cnt, rd_cycles, bad);

            is_word = (sz == 3'd4);
            bad_acc = (sz > 3'd4) || (sz >= 3'd2 && sz <= 3'd3 && a[0]) || (is_word && a[1:0] != 0);
            check("rnd_flags", bad, 0);
            check("rnd_done_cnt", done_cnt, 1);
            if (bad_acc) begin
                check("rnd_bad_err_lat", {err, 8'(lat)}, {1'b1, 8'd2});
                check("rnd_bad_no_bus", {saw_rd, saw_wr}, 0);
            end else if (na) begin
                check("rnd_tmo_err_lat", {err, 8'(lat)}, {1'b1, 8'd6});
                check("rnd_tmo_path", {saw_rd, saw_wr}, is_word ? 2'b01 : 2'b10);
            end else begin
                mask = (sz <= 3'd1) ? 32'hFF : (sz <= 3'd3) ? 32'hFFFF : 32'hFFFF_FFFF;
                sh = is_word ? 0 : 8 * a[1:0];
                exp_w = (rd & ~(mask << sh)) | ((d & mask) << sh);
                exp_lat = is_word ? 3 + ww : 4 + rw + ww;
                check("rnd_wdata", wword, exp_w);
                check("rnd_addr", baddr, {a[31:2], 2'b00});
                check("rnd_ok_err_lat", {err, 8'(lat)}, {1'b0, 8'(exp_lat)});
                check("rnd_rd_used", saw_rd, !is_word);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
